// File: rtl/alu_hold_abus.sv
// ---------------------------------------------------------------------------
// alu_hold_abus
//
// Purpose:
//   An 8-bit combinational ALU with operation selects, one adder hold
//   register, and a 16-bit address-bus output register pair.
//
//   - The ALU offers add (binary or decimal-flag mode), AND, XOR, OR and
//     shift right. When several selects are high, the highest-priority one
//     is used. The result and the flags have zero latency.
//   - The adder hold register samples the ALU result on every rising edge
//     of phi2. Its value goes to the ADL and SB buses, together with
//     independent drive enables.
//   - ABH and ABL load from the internal ADH and ADL buses under their own
//     load enables. Together they form the external address bus.
//
// Ports:
//   phi2                 in   1   clock, rising-edge active
//   rstAll               in   1   asynchronous active-high reset
//   A, B                 in   8   ALU operands
//   I_ADDC               in   1   carry in (add) / bit shifted into bit 7 (SRS)
//   DAA                  in   1   decimal-mode flag select for SUMS
//   SUMS..SRS            in   1   operation selects, priority SUMS..SRS
//   ALU_out              out  8   combinational ALU result
//   ACR, AVR, HC         out  1   carry, overflow and half-carry flags
//   ADD_ADL              in   1   hold register drives ADL
//   ADD_SB0to6, ADD_SB7  in   1   hold register drives SB[6:0] / SB[7]
//   ADL_drv, ADL_oe      out  8/1 hold value and drive enable for ADL
//   SB_drv, SB_oe        out  8/8 hold value and per-bit enable for SB
//   ADH_bus, ADL_bus     in   8   internal address buses
//   ADH_ABH, ADL_ABL     in   1   ABH / ABL load enables
//   extAB                out  16  external address bus {ABH, ABL}
// ---------------------------------------------------------------------------
module alu_hold_abus (
    input  logic        phi2,
    input  logic        rstAll,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        I_ADDC,
    input  logic        DAA,
    input  logic        SUMS,
    input  logic        ANDS,
    input  logic        EORS,
    input  logic        ORS,
    input  logic        SRS,
    output logic [7:0]  ALU_out,
    output logic        ACR,
    output logic        AVR,
    output logic        HC,
    input  logic        ADD_ADL,
    input  logic        ADD_SB0to6,
    input  logic        ADD_SB7,
    output logic [7:0]  ADL_drv,
    output logic        ADL_oe,
    output logic [7:0]  SB_drv,
    output logic [7:0]  SB_oe,
    input  logic [7:0]  ADH_bus,
    input  logic [7:0]  ADL_bus,
    input  logic        ADH_ABH,
    input  logic        ADL_ABL,
    output logic [15:0] extAB
);

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              carry;
        logic              ovf;
        logic              half;
    } aluRes_t;

    // Signed overflow of an add: the operands have the same sign, and the
    // result has the other sign.
    function automatic logic addOverflow(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] r);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic signed [DATA_W-1:0] sr;
        sa = a;
        sb = b;
        sr = r;
        return ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
    endfunction

    // Add. The result is always the binary sum. In decimal mode, the carry
    // flags are BCD digit carries. The decimal correction of the result
    // itself is done downstream.
    function automatic aluRes_t addOp(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic              cin,
                                      input logic              decimal);
        aluRes_t    r;
        logic [8:0] sum9;
        logic [4:0] lo5;
        logic [4:0] hi5;
        logic       decHalf;
        sum9    = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        lo5     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
        decHalf = (lo5 > 5'd9);
        hi5     = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, decHalf};
        r.res   = sum9[7:0];
        r.ovf   = addOverflow(a, b, sum9[7:0]);
        if (decimal) begin
            r.half  = decHalf;
            r.carry = (hi5 > 5'd9);
        end else begin
            r.half  = lo5[4];
            r.carry = sum9[8];
        end
        return r;
    endfunction

    function automatic aluRes_t logicOp(input logic [DATA_W-1:0] v);
        aluRes_t r;
        r.res   = v;
        r.carry = 1'b0;
        r.ovf   = 1'b0;
        r.half  = 1'b0;
        return r;
    endfunction

    function automatic aluRes_t shiftRightOp(input logic [DATA_W-1:0] a,
                                             input logic              cin);
        aluRes_t r;
        r.res   = {cin, a[DATA_W-1:1]};
        r.carry = a[0];
        r.ovf   = 1'b0;
        r.half  = 1'b0;
        return r;
    endfunction

    aluRes_t           aluRes;
    logic [DATA_W-1:0] holdReg_p1;
    logic [DATA_W-1:0] abh_p1;
    logic [DATA_W-1:0] abl_p1;

    // ---- Stage 0: combinational ALU (reset does not affect it) ----
    always_comb begin
        aluRes = logicOp('0);
        if (SUMS) begin
            aluRes = addOp(A, B, I_ADDC, DAA);
        end else if (ANDS) begin
            aluRes = logicOp(A & B);
        end else if (EORS) begin
            aluRes = logicOp(A ^ B);
        end else if (ORS) begin
            aluRes = logicOp(A | B);
        end else if (SRS) begin
            aluRes = shiftRightOp(A, I_ADDC);
        end
    end

    assign ALU_out = aluRes.res;
    assign ACR     = aluRes.carry;
    assign AVR     = aluRes.ovf;
    assign HC      = aluRes.half;

    // ---- Stage 1: hold register and address registers ----
    always_ff @(posedge phi2 or posedge rstAll) begin
        if (rstAll) begin
            holdReg_p1 <= '0;
        end else begin
            holdReg_p1 <= aluRes.res;
        end
    end

    always_ff @(posedge phi2 or posedge rstAll) begin
        if (rstAll) begin
            abh_p1 <= '0;
            abl_p1 <= '0;
        end else begin
            if (ADH_ABH) abh_p1 <= ADH_bus;
            if (ADL_ABL) abl_p1 <= ADL_bus;
        end
    end

    // The enables pass straight through and stay active during reset. That
    // way a bus owner in reset still drives a defined 0x00.
    assign ADL_drv = holdReg_p1;
    assign SB_drv  = holdReg_p1;
    assign ADL_oe  = ADD_ADL;
    assign SB_oe   = {ADD_SB7, {7{ADD_SB0to6}}};

    assign extAB = {abh_p1, abl_p1};

    logic [ADDR_W-1:0] unusedWidthTie;
    assign unusedWidthTie = extAB;

endmodule

// File: tb/tb_alu_hold_abus.sv
module tb_alu_hold_abus;

    logic        phi2 = 1'b0;
    logic        rstAll;
    logic [7:0]  A, B;
    logic        I_ADDC, DAA, SUMS, ANDS, EORS, ORS, SRS;
    logic [7:0]  ALU_out;
    logic        ACR, AVR, HC;
    logic        ADD_ADL, ADD_SB0to6, ADD_SB7;
    logic [7:0]  ADL_drv, SB_drv, SB_oe;
    logic        ADL_oe;
    logic [7:0]  ADH_bus, ADL_bus;
    logic        ADH_ABH, ADL_ABL;
    logic [15:0] extAB;

    alu_hold_abus dut (
        .phi2(phi2), .rstAll(rstAll), .A(A), .B(B), .I_ADDC(I_ADDC), .DAA(DAA),
        .SUMS(SUMS), .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS),
        .ALU_out(ALU_out), .ACR(ACR), .AVR(AVR), .HC(HC),
        .ADD_ADL(ADD_ADL), .ADD_SB0to6(ADD_SB0to6), .ADD_SB7(ADD_SB7),
        .ADL_drv(ADL_drv), .ADL_oe(ADL_oe), .SB_drv(SB_drv), .SB_oe(SB_oe),
        .ADH_bus(ADH_bus), .ADL_bus(ADL_bus), .ADH_ABH(ADH_ABH), .ADL_ABL(ADL_ABL),
        .extAB(extAB)
    );

    always #5 phi2 = ~phi2;

    typedef struct {
        int          idx;
        logic [7:0]  aluOut;
        logic        acr, avr, hc;
        logic [7:0]  hold;
        logic        adlOe;
        logic [7:0]  sbOe;
        logic [15:0] ab;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   vecNum = 0;

    // Model of the registered state, advanced on each edge
    logic [7:0]  mHold = 8'h00;
    logic [15:0] mAb   = 16'h0000;
    logic        pRst = 1'b1, pAdhAbh = 1'b0, pAdlAbl = 1'b0;
    logic [7:0]  pOut = 8'h00, pAdhBus = 8'h00, pAdlBus = 8'h00;

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per falling edge
    always @(negedge phi2) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("ALU_out", e.idx, {8'h00, ALU_out}, {8'h00, e.aluOut});
            chk("ACR",     e.idx, {15'h0, ACR},     {15'h0, e.acr});
            chk("AVR",     e.idx, {15'h0, AVR},     {15'h0, e.avr});
            chk("HC",      e.idx, {15'h0, HC},      {15'h0, e.hc});
            chk("ADL_drv", e.idx, {8'h00, ADL_drv}, {8'h00, e.hold});
            chk("SB_drv",  e.idx, {8'h00, SB_drv},  {8'h00, e.hold});
            chk("ADL_oe",  e.idx, {15'h0, ADL_oe},  {15'h0, e.adlOe});
            chk("SB_oe",   e.idx, {8'h00, SB_oe},   {8'h00, e.sbOe});
            chk("extAB",   e.idx, extAB,            e.ab);
        end
    end

    // sel = {SUMS, ANDS, EORS, ORS, SRS}
    task automatic step(input logic r, input logic [4:0] sel, input logic daa,
                        input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic adl, input logic sb06, input logic sb7,
                        input logic [7:0] hBus, input logic [7:0] lBus,
                        input logic hLd, input logic lLd,
                        input logic [7:0] eOut, input logic eAcr,
                        input logic eAvr, input logic eHc);
        exp_t e;
        @(posedge phi2);
        if (pRst) begin
            mHold = 8'h00;
            mAb   = 16'h0000;
        end else begin
            mHold = pOut;
            if (pAdhAbh) mAb[15:8] = pAdhBus;
            if (pAdlAbl) mAb[7:0]  = pAdlBus;
        end
        #1;
        rstAll = r;
        {SUMS, ANDS, EORS, ORS, SRS} = sel;
        DAA = daa; A = a; B = b; I_ADDC = cin;
        ADD_ADL = adl; ADD_SB0to6 = sb06; ADD_SB7 = sb7;
        ADH_bus = hBus; ADL_bus = lBus; ADH_ABH = hLd; ADL_ABL = lLd;
        if (r) begin
            mHold = 8'h00;
            mAb   = 16'h0000;
        end
        pRst = r; pOut = eOut; pAdhBus = hBus; pAdlBus = lBus;
        pAdhAbh = hLd; pAdlAbl = lLd;
        e.idx = vecNum; e.aluOut = eOut; e.acr = eAcr; e.avr = eAvr; e.hc = eHc;
        e.hold = mHold; e.adlOe = adl; e.sbOe = {sb7, {7{sb06}}}; e.ab = mAb;
        sbq.push_back(e);
        vecNum++;
    endtask

    initial begin
        rstAll = 1'b1;
        {SUMS, ANDS, EORS, ORS, SRS} = 5'b0;
        DAA = 0; A = 0; B = 0; I_ADDC = 0;
        ADD_ADL = 0; ADD_SB0to6 = 0; ADD_SB7 = 0;
        ADH_bus = 0; ADL_bus = 0; ADH_ABH = 0; ADL_ABL = 0;

        //   r  sel       daa a      b      ci adl s06 s7 hBus   lBus   hLd lLd eOut   C  V  H
        // Reset with loads enabled; the ALU keeps working
        step(1, 5'b10000, 0, 8'h7F, 8'h01, 0, 0, 0, 0, 8'hAA, 8'h55, 1, 1, 8'h80, 0, 1, 1);
        step(1, 5'b10000, 0, 8'h7F, 8'h01, 0, 1, 1, 0, 8'hAA, 8'h55, 1, 1, 8'h80, 0, 1, 1);
        // No select
        step(0, 5'b00000, 0, 8'h12, 8'h34, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        // Signed overflow, then SB drive
        step(0, 5'b10000, 0, 8'h7F, 8'h01, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 8'h80, 0, 1, 1);
        step(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        // Carry out, then ADL drive
        step(0, 5'b10000, 0, 8'hFF, 8'h01, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h01, 1, 0, 1);
        step(0, 5'b00000, 0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        // Negative overflow with carry
        step(0, 5'b10000, 0, 8'h80, 8'h80, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 1, 0);
        // Decimal flags
        step(0, 5'b10000, 1, 8'h09, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h0A, 0, 0, 1);
        step(0, 5'b10000, 1, 8'h99, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h9A, 1, 0, 1);
        // Logic ops, with extra lower-priority selects high
        step(0, 5'b01110, 0, 8'hF0, 8'h3C, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h30, 0, 0, 0);
        step(0, 5'b00111, 0, 8'hF0, 8'h3C, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hCC, 0, 0, 0);
        step(0, 5'b00011, 0, 8'hF0, 8'h3C, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hFC, 0, 0, 0);
        // Shift right
        step(0, 5'b00001, 0, 8'h81, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hC0, 1, 0, 0);
        step(0, 5'b00001, 0, 8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        // SUMS beats ANDS
        step(0, 5'b11000, 0, 8'h10, 8'h20, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h30, 0, 0, 0);
        // Split address load
        step(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h12, 8'h34, 1, 0, 8'h00, 0, 0, 0);
        step(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h56, 8'h34, 0, 1, 8'h00, 0, 0, 0);
        step(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h9A, 8'hBC, 0, 0, 8'h00, 0, 0, 0);
        // Hold register captures a value, then a mid-operation reset clears it
        step(0, 5'b00100, 0, 8'hA5, 8'h0F, 0, 1, 1, 1, 8'h00, 8'h00, 0, 0, 8'hAA, 0, 0, 0);
        step(1, 5'b00100, 0, 8'hA5, 8'h0F, 0, 1, 1, 1, 8'hEE, 8'hDD, 1, 1, 8'hAA, 0, 0, 0);
        step(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);

        begin
            int guard = 0;
            while (sbq.size() > 0 && guard < 100) begin
                @(posedge phi2);
                guard++;
            end
            if (sbq.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d entries left, expected 0", sbq.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
